// File: rtl/count_unary_serializer.sv
// Re-expands a binary ones-count into a thermometer frame sent LSB first, one bit per clock.
// Optional trailing even-parity bit when UNARY_PARITY_EN is defined.
module count_unary_serializer #(
    parameter int N_BITS = 3,
    parameter int CW     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [CW-1:0] in_count_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_bit_o,
    output logic          out_last_o,
    output logic          ovf_o
);

`ifdef UNARY_PARITY_EN
    localparam int FL = N_BITS + 1;
`else
    localparam int FL = N_BITS;
`endif
    localparam int IW = (FL > 1) ? $clog2(FL) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q;
    logic [FL-1:0]   sr_q;
    logic [IW-1:0]   idx_q;
    logic            out_bit_q;
    logic            out_last_q;
    logic            ovf_q;

    logic [FL-1:0]   frame_d;
    logic [IW-1:0]   idx_d;
    logic            ovf_hit;
    logic            in_xfer;
    logic            out_xfer;

    // Data bit i is set iff i < count; bits past N_BITS never exist, which is the clamp.
    always_comb begin
        frame_d = '0;
        for (int i = 0; i < N_BITS; i++)
            frame_d[i] = (i < int'(in_count_i));
`ifdef UNARY_PARITY_EN
        frame_d[FL-1] = ^frame_d[N_BITS-1:0];
`endif
    end

    assign ovf_hit     = int'(in_count_i) > N_BITS;
    assign idx_d       = idx_q + 1'b1;
    assign out_valid_o = (state_q == SHIFT);
    assign out_xfer    = out_valid_o && out_ready_i;
    assign in_ready_o  = (state_q == IDLE) || (out_xfer && out_last_q);
    assign in_xfer     = in_valid_i && in_ready_o;
    assign out_bit_o   = out_bit_q;
    assign out_last_o  = out_last_q;
    assign ovf_o       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            idx_q      <= '0;
            out_bit_q  <= 1'b0;
            out_last_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (in_xfer && ovf_hit)
                ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        state_q    <= SHIFT;
                        out_bit_q  <= frame_d[0];
                        sr_q       <= frame_d >> 1;
                        idx_q      <= '0;
                        out_last_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (out_xfer) begin
                        if (!out_last_q) begin
                            out_bit_q  <= sr_q[0];
                            sr_q       <= sr_q >> 1;
                            idx_q      <= idx_d;
                            out_last_q <= (int'(idx_d) == FL - 1);
                        end else if (in_xfer) begin
                            // Back-to-back: next frame's bit 0 follows the last bit directly.
                            out_bit_q  <= frame_d[0];
                            sr_q       <= frame_d >> 1;
                            idx_q      <= '0;
                            out_last_q <= 1'b0;
                        end else begin
                            state_q    <= IDLE;
                            out_bit_q  <= 1'b0;
                            out_last_q <= 1'b0;
                            sr_q       <= '0;
                            idx_q      <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
